// File: rtl/buffer_execute.sv
// buffer_execute: dual-write, single-drain circular queue that sits between
// the dispatch stage and the execute stage.
//
// Ports:
//   clk, rst_n          rising-edge clock; asynchronous active-low reset
//   write1 / data1_in   enqueue the older packet of the pair
//   write2 / data2_in   enqueue the younger packet of the pair
//   buf_full            fewer than two free entries (back-pressure to dispatch)
//   data_out            registered packet issued to execute, one per cycle
//
// Up to two packets go in per cycle and one comes out per cycle, oldest
// first. The queue never stalls its output: each issued packet is held for
// exactly one cycle, and data_out is zero in any cycle that follows an empty
// queue.
module buffer_execute #(
  parameter int WIDTH = 128,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             write1,
  input  logic             write2,
  input  logic [WIDTH-1:0] data1_in,
  input  logic [WIDTH-1:0] data2_in,
  output logic             buf_full,
  output logic [WIDTH-1:0] data_out
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rd_ptr, wr_ptr, wr_idx2;
  logic [CW-1:0]    count, free;
  logic             acc1, acc2, pop;

  // Acceptance is based only on the occupancy at the start of the cycle.
  // A pop in the same cycle does not free a slot for that cycle's writes.
  assign free = CW'(DEPTH) - count;
  assign acc1 = write1 && (free >= CW'(1));
  assign acc2 = write2 && (free >= (CW'(1) + CW'(acc1)));
  assign pop  = (count != '0);

  // If write1 is dropped or idle, a lone write2 takes the head slot.
  assign wr_idx2 = wr_ptr + PW'(acc1);

  // Full means a dual write might not fit. Dispatch can therefore always
  // issue a pair whenever this signal is low.
  assign buf_full = (count >= CW'(DEPTH - 1));

  // Storage is not reset. Only the pointers and count define what is valid.
  // Writes land only in free slots, so they never alias the slot being read.
  always_ff @(posedge clk) begin
    if (acc1) mem[wr_ptr]  <= data1_in;
    if (acc2) mem[wr_idx2] <= data2_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      data_out <= '0;
    end else begin
      wr_ptr <= wr_ptr + PW'(acc1) + PW'(acc2);
      count  <= count - CW'(pop) + CW'(acc1) + CW'(acc2);
      if (pop) begin
        data_out <= mem[rd_ptr];
        rd_ptr   <= rd_ptr + PW'(1);
      end else begin
        data_out <= '0;
      end
    end
  end

endmodule

// File: tb/tb_buffer_execute.sv
// Testbench for buffer_execute. It combines directed vector tables, hand
// sequences for the fill, overflow, wrap and async-reset cases, and a
// randomized run. All of these are checked against a queue-based reference
// model.
module tb_buffer_execute;

  localparam int W = 128;
  localparam int D = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         write1, write2;
  logic [W-1:0] data1_in, data2_in;
  logic         buf_full;
  logic [W-1:0] data_out;

  int n_checks = 0;
  int n_err    = 0;

  logic [W-1:0] q[$];

  buffer_execute #(.WIDTH(W), .DEPTH(D)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .write1   (write1),
    .write2   (write2),
    .data1_in (data1_in),
    .data2_in (data2_in),
    .buf_full (buf_full),
    .data_out (data_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         w1, w2;
    logic [W-1:0] d1, d2;
    logic [W-1:0] eout;
    logic         efull;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic w1, logic w2, int d1, int d2, int eo, logic ef);
    vec_t v;
    v.w1 = w1; v.w2 = w2;
    v.d1 = W'(d1); v.d2 = W'(d2);
    v.eout = W'(eo); v.efull = ef;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  // Reference model. The queue content is the set of valid entries in order.
  // The pop is taken from the pre-edge state, and writes are admitted
  // against the pre-pop occupancy.
  task automatic step(input logic w1, input logic w2,
                      input logic [W-1:0] d1, input logic [W-1:0] d2);
    logic [W-1:0] e;
    int  n, free;
    bit  a1, a2;
    write1 = w1; write2 = w2; data1_in = d1; data2_in = d2;
    n = q.size();
    e = '0;
    if (n > 0) e = q.pop_front();
    free = D - n;
    a1 = w1 && (free >= 1);
    a2 = w2 && (free >= 1 + int'(a1));
    if (a1) q.push_back(d1);
    if (a2) q.push_back(d2);
    @(posedge clk); #1;
    chk("data_out", data_out, e);
    chk("buf_full", W'(buf_full), W'(q.size() >= D - 1));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, '0);
  endtask

  logic [W-1:0] va, vb;
  bit seen_a, seen_b;

  initial begin
    rst_n = 1'b0; write1 = 1'b0; write2 = 1'b0; data1_in = '0; data2_in = '0;

    // Reset is held for two cycles.
    repeat (2) @(posedge clk);
    #1;
    chk("reset data_out", data_out, '0);
    chk("reset buf_full", W'(buf_full), '0);
    #3 rst_n = 1'b1;

    // Directed table: a write2-only stream, then a single dual write.
    for (int i = 0; i < 5; i++) tbl.push_back(mk(0, 1, 0, 200, (i == 0) ? 0 : 200, 0));
    tbl.push_back(mk(0, 0, 0, 0, 200, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 1, 100, 200, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 100, 0));
    tbl.push_back(mk(0, 0, 0, 0, 200, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0));
    foreach (tbl[i]) begin
      step(tbl[i].w1, tbl[i].w2, tbl[i].d1, tbl[i].d2);
      chk($sformatf("tbl[%0d] data_out", i), data_out, tbl[i].eout);
      chk($sformatf("tbl[%0d] buf_full", i), W'(buf_full), W'(tbl[i].efull));
    end

    // Fill with dual writes. Occupancy reaches k+1 after k cycles.
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 1'b1, W'(2*i+1), W'(2*i+2));
      chk("fill buf_full", W'(buf_full), W'(i == 5));
    end

    // Overflow: with 7 entries queued, only A fits and B is dropped.
    va = W'(32'hA0A0); vb = W'(32'hB0B0);
    seen_a = 0; seen_b = 0;
    step(1'b1, 1'b1, va, vb);
    chk("overflow buf_full", W'(buf_full), W'(1));
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b0, '0, '0);
      if (data_out === va) seen_a = 1;
      if (data_out === vb) seen_b = 1;
    end
    chk("overflow A drained", W'(seen_a), W'(1));
    chk("overflow B dropped", W'(seen_b), W'(0));

    // Wrap-around: 31 single writes pass through the pointers several times.
    for (int i = 0; i <= 30; i++) step(1'b1, 1'b0, W'(i), '0);
    idle(2);

    // Async reset asserted mid-cycle with entries queued.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, W'(300 + 2*i), W'(301 + 2*i));
    write1 = 1'b0; write2 = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("async reset data_out", data_out, '0);
    chk("async reset buf_full", W'(buf_full), '0);
    q.delete();
    #2 rst_n = 1'b1;
    idle(3);

    // Randomized traffic, biased toward writes so the full region gets exercised.
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 3) != 0), ($urandom_range(0, 2) != 0),
           {$urandom(), $urandom(), $urandom(), $urandom()},
           {$urandom(), $urandom(), $urandom(), $urandom()});
    end
    idle(D + 2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/buffer_execute.md
Name: buffer_execute

Overview:
- Dual-write, single-drain circular queue between the dispatch stage and the execute stage.
- Dispatch can deposit up to two 128-bit execute packets per cycle.
- The buffer issues one packet per cycle, oldest first, on a registered output.
- buf_full is the back-pressure signal to dispatch.

Parameters:
- WIDTH, 128, packet width in bits.
- DEPTH, 8, number of entries (power of two, minimum 4).

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- write1  input  1  enqueue data1_in this cycle.
- write2  input  1  enqueue data2_in this cycle.
- data1_in  input  WIDTH  first (older) packet.
- data2_in  input  WIDTH  second (younger) packet.
- buf_full  output  1  fewer than two free entries.
- data_out  output  WIDTH  packet issued to execute (registered).

Behaviour:
- Interface: one clock (clk); reset rst_n is asynchronous, active-low.
- Reset (rst_n low, immediate, no clock needed):
  - rd_ptr, wr_ptr and count cleared to 0.
  - data_out = 0; buf_full = 0.
  - Memory contents need not be cleared.
  - Reset asserted mid-operation discards all queued entries.
- Storage: DEPTH x WIDTH array; rd_ptr and wr_ptr of log2(DEPTH) bits; count of log2(DEPTH)+1 bits. Pointers wrap modulo DEPTH.
- Write acceptance at each rising edge, computed from the count at the start of the cycle. Same-cycle pops give no credit.
  - free = DEPTH - count.
  - write1 is accepted if free >= 1.
  - write2 is accepted if free >= (1 + accepted write1).
  - Rejected writes are silently dropped. write1 has priority.
- Write ordering:
  - If both writes are accepted, data1_in goes to mem[wr_ptr] and data2_in to mem[wr_ptr+1]; wr_ptr advances by 2.
  - If only one is accepted, it goes to mem[wr_ptr]; wr_ptr advances by 1.
  - write2 alone is legal and enqueues data2_in at mem[wr_ptr].
- Drain at each rising edge:
  - If count > 0 at the start of the cycle: data_out <= mem[rd_ptr]; rd_ptr advances by 1.
  - If count == 0: data_out <= 0. No bypass from same-cycle inputs.
- Count update: count <= count - pop + accepted writes (pop is 0 or 1; accepted writes are 0 to 2).
- Latency:
  - A packet written at edge N appears on data_out after edge N+1 at the earliest.
  - With a dual write at edge N, data1 appears after edge N+1 and data2 after edge N+2 (assuming an empty queue).
- Each data_out value is held for exactly one cycle. There is no downstream stall.
- buf_full is combinational from the registered count: buf_full = (count >= DEPTH-1).
  - It therefore guarantees that a dual write is accepted whenever buf_full = 0.
- Simultaneous pop and writes on a full or near-full queue are legal. Acceptance still uses the pre-pop count.
- X on data inputs is stored as-is. X on write1/write2 is never expected after reset.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles -> data_out=0, buf_full=0. Assert rst_n asynchronously mid-cycle with entries queued -> outputs clear immediately; later data_out=0 until new writes arrive.
- Single port 2 stream: rst_n=1, write1=0, write2=1, data2_in=200 held for 5 cycles -> data_out=0 after the first edge, then 200 every cycle. count stays at 1, buf_full=0.
- Dual write once: empty queue, one cycle with write1=write2=1, data1_in=100, data2_in=200 -> data_out=100, then 200, then 0.
- Fill: write1=write2=1 every cycle with incrementing data, DEPTH=8 -> count grows by 1 per cycle; buf_full rises once count=7. Output order is strictly 1,2,3,... with no loss while buf_full=0.
- Overflow drop: with count=7, request both writes (A, B) -> only A is accepted, B is dropped. The drained sequence contains A but not B.
- Wrap-around: run more than 3*DEPTH single writes with values 0..30 -> data_out reproduces 0..30 in order across pointer wrap.
